// File: rtl/vec_pingpong_buffer.sv
// Double-buffered vector store between the matrix-vector product stage and the next layer.
// The producer fills one bank element by element while the consumer reads the other bank in chunks.
module vec_pingpong_buffer #(
    parameter int VecLength   = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 16
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       wr_en,
    input  logic signed [NBits-1:0]                    wr_data,
    input  logic                                       wr_vec_done,
    output logic                                       wr_full,
    input  logic                                       rd_req_chunk,
    input  logic                                       rd_ptr_rst,
    input  logic                                       rd_release,
    output logic signed [WorkingRegs-1:0][NBits-1:0]   rd_data,
    output logic                                       rd_ready,
    output logic                                       err_overflow
);

    localparam int NChunks = (VecLength + WorkingRegs - 1) / WorkingRegs;
    localparam int PtrW    = (NChunks > 1) ? $clog2(NChunks) : 1;
    localparam int IdxW    = $clog2(VecLength + 1);

    logic signed [NBits-1:0] mem [2][VecLength];
    logic [1:0]              valid;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [IdxW-1:0]         wr_idx;
    logic [PtrW-1:0]         rd_ptr;

    logic wr_accept;
    logic wr_drop;
    logic commit_ok;
    logic commit_drop;
    logic release_ok;

    assign rd_ready    = valid[rd_bank];
    assign wr_full     = valid[wr_bank];
    assign wr_accept   = wr_en && !wr_full && (wr_idx < IdxW'(VecLength));
    assign wr_drop     = wr_en && !wr_accept;
    assign commit_ok   = wr_vec_done && !wr_full;
    assign commit_drop = wr_vec_done && wr_full;
    assign release_ok  = rd_release && rd_ready;

    // Released banks are zeroed so a later short vector reads 0 in its unwritten tail.
    // Writes never hit the bank being released: that bank is valid, so writing into it means wr_full.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < VecLength; e++) begin
                    mem[b][e] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < VecLength; e++) begin
                    if (release_ok && (rd_bank == 1'(b))) begin
                        mem[b][e] <= '0;
                    end else if (wr_accept && (wr_bank == 1'(b)) && (wr_idx == IdxW'(e))) begin
                        mem[b][e] <= wr_data;
                    end
                end
            end
        end
    end

    // Commit and release always touch different banks when both are accepted.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid        <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_idx       <= '0;
            rd_ptr       <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (commit_ok) begin
                valid[wr_bank] <= 1'b1;
                wr_bank        <= ~wr_bank;
                wr_idx         <= '0;
            end else if (wr_accept) begin
                wr_idx <= wr_idx + IdxW'(1);
            end

            if (release_ok) begin
                valid[rd_bank] <= 1'b0;
                rd_bank        <= ~rd_bank;
            end

            if (release_ok || rd_ptr_rst) begin
                rd_ptr <= '0;
            end else if (rd_req_chunk) begin
                rd_ptr <= (rd_ptr == PtrW'(NChunks - 1)) ? '0 : rd_ptr + PtrW'(1);
            end

            if (wr_drop || commit_drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Lanes past the end of the vector stay 0 on the ragged final chunk.
    always_comb begin
        rd_data = '0;
        if (rd_ready) begin
            for (int lane = 0; lane < WorkingRegs; lane++) begin
                for (int e = 0; e < VecLength; e++) begin
                    if ((int'(rd_ptr) * WorkingRegs + lane) == e) begin
                        rd_data[lane] = mem[rd_bank][e];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_pingpong_buffer.sv
// Directed bench for vec_pingpong_buffer: a vector table for the main fill/read/ping-pong flow,
// plus hand sequences for async reset, the ragged 10-element configuration and a product-stage feed.
module tb_vec_pingpong_buffer;

    localparam int NBits = 16;
    localparam int WR    = 4;

    typedef logic [WR-1:0][NBits-1:0] chunk_t;

    typedef struct {
        string             name;
        logic              we;
        logic [NBits-1:0]  wd;
        logic              done;
        logic              req;
        logic              prst;
        logic              rel;
        logic              exp_ready;
        logic              exp_full;
        logic              exp_err;
        chunk_t            exp_chunk;
    } vec_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                              rst_in;
    logic                              wr_en, wr_vec_done, rd_req_chunk, rd_ptr_rst, rd_release;
    logic signed [NBits-1:0]           wr_data;
    logic                              wr_full, rd_ready, err_overflow;
    logic signed [WR-1:0][NBits-1:0]   rd_data;

    logic                              s_wr_en, s_wr_vec_done, s_rd_req_chunk, s_rd_ptr_rst, s_rd_release;
    logic signed [NBits-1:0]           s_wr_data;
    logic                              s_wr_full, s_rd_ready, s_err_overflow;
    logic signed [WR-1:0][NBits-1:0]   s_rd_data;

    vec_pingpong_buffer #(.VecLength(16), .WorkingRegs(WR), .NBits(NBits)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_en(wr_en), .wr_data(wr_data), .wr_vec_done(wr_vec_done), .wr_full(wr_full),
        .rd_req_chunk(rd_req_chunk), .rd_ptr_rst(rd_ptr_rst), .rd_release(rd_release),
        .rd_data(rd_data), .rd_ready(rd_ready), .err_overflow(err_overflow)
    );

    vec_pingpong_buffer #(.VecLength(10), .WorkingRegs(WR), .NBits(NBits)) dut10 (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_vec_done(s_wr_vec_done), .wr_full(s_wr_full),
        .rd_req_chunk(s_rd_req_chunk), .rd_ptr_rst(s_rd_ptr_rst), .rd_release(s_rd_release),
        .rd_data(s_rd_data), .rd_ready(s_rd_ready), .err_overflow(s_err_overflow)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    function automatic chunk_t mkChunk(int c0, int c1, int c2, int c3);
        return {NBits'(c3), NBits'(c2), NBits'(c1), NBits'(c0)};
    endfunction

    function automatic void addVec(string name, logic we, int wd, logic done, logic req,
                                   logic prst, logic rel, logic r, logic f, logic e,
                                   int c0, int c1, int c2, int c3);
        vec_t v;
        v.name = name; v.we = we; v.wd = NBits'(wd); v.done = done; v.req = req;
        v.prst = prst; v.rel = rel; v.exp_ready = r; v.exp_full = f; v.exp_err = e;
        v.exp_chunk = mkChunk(c0, c1, c2, c3);
        tbl.push_back(v);
    endfunction

    task automatic checkValue(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string name, logic r, logic f, logic e, chunk_t c);
        checkValue({name, ".rd_ready"}, 64'(rd_ready), 64'(r));
        checkValue({name, ".wr_full"}, 64'(wr_full), 64'(f));
        checkValue({name, ".err_overflow"}, 64'(err_overflow), 64'(e));
        checkValue({name, ".rd_data"}, 64'(rd_data), 64'(c));
    endtask

    task automatic applyStimulus(vec_t v);
        wr_en = v.we; wr_data = v.wd; wr_vec_done = v.done;
        rd_req_chunk = v.req; rd_ptr_rst = v.prst; rd_release = v.rel;
        @(posedge clk_in); #1;
        wr_en = 0; wr_data = '0; wr_vec_done = 0; rd_req_chunk = 0; rd_ptr_rst = 0; rd_release = 0;
        checkOutput(v.name, v.exp_ready, v.exp_full, v.exp_err, v.exp_chunk);
    endtask

    task automatic runTable();
        foreach (tbl[i]) applyStimulus(tbl[i]);
        tbl.delete();
    endtask

    task automatic doReset();
        rst_in = 1;
        @(posedge clk_in); #1;
        rst_in = 0;
    endtask

    initial begin
        int w[4][4];
        int x[4];
        int y[4];

        rst_in = 1;
        wr_en = 0; wr_data = '0; wr_vec_done = 0; rd_req_chunk = 0; rd_ptr_rst = 0; rd_release = 0;
        s_wr_en = 0; s_wr_data = '0; s_wr_vec_done = 0; s_rd_req_chunk = 0; s_rd_ptr_rst = 0; s_rd_release = 0;
        #1;
        checkOutput("reset", 0, 0, 0, '0);
        @(posedge clk_in); #1;
        rst_in = 0;

        // Fill, read through all chunks, wrap, and rewind.
        for (int i = 0; i < 16; i++) addVec("fill_a", 1, i + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec("commit_a", 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 2, 3, 4);
        addVec("req_1",    0, 0, 0, 1, 0, 0, 1, 0, 0, 5, 6, 7, 8);
        addVec("req_2",    0, 0, 0, 1, 0, 0, 1, 0, 0, 9, 10, 11, 12);
        addVec("req_3",    0, 0, 0, 1, 0, 0, 1, 0, 0, 13, 14, 15, 16);
        addVec("req_wrap", 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2, 3, 4);
        addVec("req_4",    0, 0, 0, 1, 0, 0, 1, 0, 0, 5, 6, 7, 8);
        addVec("ptr_rst",  0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 2, 3, 4);
        // Ping-pong: second vector fills while the first is readable.
        for (int i = 0; i < 16; i++) addVec("fill_b", 1, -(i + 1), 0, 0, 0, 0, 1, 0, 0, 1, 2, 3, 4);
        addVec("commit_b",   0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 2, 3, 4);
        addVec("drop_write", 1, 17, 0, 0, 0, 0, 1, 1, 1, 1, 2, 3, 4);
        addVec("release_a",  0, 0, 0, 0, 0, 1, 1, 0, 1, -1, -2, -3, -4);
        addVec("release_b",  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        // Short vector into the bank just cleared by release.
        for (int i = 0; i < 6; i++) addVec("fill_short", 1, i + 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        addVec("commit_short", 0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 2, 3, 4);
        addVec("short_c1",     0, 0, 0, 1, 0, 0, 1, 0, 1, 5, 6, 0, 0);
        addVec("short_c2",     0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        addVec("short_c3",     0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        addVec("short_wrap",   0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 2, 3, 4);
        // Same-cycle write and commit.
        for (int i = 0; i < 3; i++) addVec("fill_c", 1, 21 + i, 0, 0, 0, 0, 1, 0, 1, 1, 2, 3, 4);
        addVec("write_commit", 1, 24, 1, 0, 0, 0, 1, 1, 1, 1, 2, 3, 4);
        addVec("release_s",    0, 0, 0, 0, 0, 1, 1, 0, 1, 21, 22, 23, 24);
        // Release and commit together with one bank valid.
        addVec("fill_d", 1, 31, 0, 0, 0, 0, 1, 0, 1, 21, 22, 23, 24);
        addVec("fill_d", 1, 32, 0, 0, 0, 0, 1, 0, 1, 21, 22, 23, 24);
        addVec("rel_commit", 0, 0, 1, 0, 0, 1, 1, 0, 1, 31, 32, 0, 0);
        // Release and commit together while full: the commit is lost.
        addVec("fill_e",      1, 41, 0, 0, 0, 0, 1, 0, 1, 31, 32, 0, 0);
        addVec("commit_e",    0, 0, 1, 0, 0, 0, 1, 1, 1, 31, 32, 0, 0);
        addVec("rel_commit_full", 0, 0, 1, 0, 0, 1, 1, 0, 1, 41, 0, 0, 0);
        addVec("write_commit_f",  1, 51, 1, 0, 0, 0, 1, 1, 1, 41, 0, 0, 0);
        addVec("release_f",   0, 0, 0, 0, 0, 1, 1, 0, 1, 51, 0, 0, 0);
        runTable();

        // Async reset between edges with one bank committed and a partial write in progress.
        addVec("partial_g", 1, 61, 0, 0, 0, 0, 1, 0, 1, 51, 0, 0, 0);
        runTable();
        #3;
        rst_in = 1;
        #1;
        checkOutput("async_rst", 0, 0, 0, '0);
        @(posedge clk_in); #1;
        rst_in = 0;

        // Fresh fill after reset, overfilling by one element.
        for (int i = 0; i < 16; i++) addVec("refill", 1, 100 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec("idx_overflow", 1, 999, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        addVec("refill_commit", 0, 0, 1, 0, 0, 0, 1, 0, 1, 100, 101, 102, 103);
        addVec("refill_c1", 0, 0, 0, 1, 0, 0, 1, 0, 1, 104, 105, 106, 107);
        addVec("refill_c2", 0, 0, 0, 1, 0, 0, 1, 0, 1, 108, 109, 110, 111);
        addVec("refill_c3", 0, 0, 0, 1, 0, 0, 1, 0, 1, 112, 113, 114, 115);
        runTable();

        // Commit dropped while full sets the sticky error on its own.
        doReset();
        addVec("empty_commit1", 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        addVec("empty_commit2", 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        addVec("commit_drop",   0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        addVec("release_h",     0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        runTable();

        // Ragged final chunk with VecLength=10.
        for (int i = 0; i < 10; i++) begin
            s_wr_en = 1; s_wr_data = NBits'(i + 1);
            @(posedge clk_in); #1;
        end
        s_wr_en = 0; s_wr_data = '0; s_wr_vec_done = 1;
        @(posedge clk_in); #1;
        s_wr_vec_done = 0;
        checkValue("len10.rd_ready", 64'(s_rd_ready), 64'(1'b1));
        checkValue("len10.c0", 64'(s_rd_data), 64'(mkChunk(1, 2, 3, 4)));
        s_rd_req_chunk = 1;
        @(posedge clk_in); #1;
        checkValue("len10.c1", 64'(s_rd_data), 64'(mkChunk(5, 6, 7, 8)));
        @(posedge clk_in); #1;
        checkValue("len10.c2", 64'(s_rd_data), 64'(mkChunk(9, 10, 0, 0)));
        @(posedge clk_in); #1;
        s_rd_req_chunk = 0;
        checkValue("len10.wrap", 64'(s_rd_data), 64'(mkChunk(1, 2, 3, 4)));
        checkValue("len10.err", 64'(s_err_overflow), 64'(1'b0));

        // Product-stage feed: identity weights times {1,2,3,4}, one element per row flush.
        doReset();
        x = '{1, 2, 3, 4};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) w[r][c] = (r == c) ? 1 : 0;
        for (int r = 0; r < 4; r++) begin
            y[r] = 0;
            for (int c = 0; c < 4; c++) y[r] += w[r][c] * x[c];
        end
        for (int r = 0; r < 4; r++) begin
            wr_en = 1; wr_data = NBits'(y[r]); wr_vec_done = (r == 3);
            @(posedge clk_in); #1;
        end
        wr_en = 0; wr_data = '0; wr_vec_done = 0;
        checkOutput("matvec", 1, 0, 0, mkChunk(1, 2, 3, 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
